rf_wb_sink: RTL and testbench

//  Register file that consumes the writeback stage's rf_w_data_DM_WB: the receiving end of the DM/WB write path.
//  It provides two synchronous read ports for ID/EX and write-to-read bypass, so a WB write is visible to a same-cycle read.
//  A load scoreboard marks registers with an outstanding DM load and raises stall until the load data is written back.

---
 rtl/rf_wb_sink.sv | 90 +++++++++
 tb/tb_rf_wb_sink.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sink.sv
// Register file at the DM/WB writeback sink: two registered read ports,
// write-to-read bypass and a load scoreboard that raises stall on load-use.
module rf_wb_sink #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              re0,
  input  logic              re1,
  input  logic              we,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] dst,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst_addr,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic              stall
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   r_p0;
  logic [DATA_W-1:0]   r_p1;

  logic [DATA_W-1:0]   w_val0;
  logic [DATA_W-1:0]   w_val1;
  logic                w_byp0;
  logic                w_byp1;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_stall;

  assign w_byp0 = we && (dst_addr == p0_addr);
  assign w_byp1 = we && (dst_addr == p1_addr);

  always_comb begin
    w_val0 = r_regs[p0_addr];
    w_val1 = r_regs[p1_addr];
    if (w_byp0) w_val0 = dst;
    if (w_byp1) w_val1 = dst;
    if (p0_addr == '0) w_val0 = '0;
    if (p1_addr == '0) w_val1 = '0;
  end

  // a load completing this cycle is bypassed, so it does not stall
  assign w_hit0  = r_busy[p0_addr] && !w_byp0;
  assign w_hit1  = r_busy[p1_addr] && !w_byp1;
  assign w_stall = (re0 && w_hit0) || (re1 && w_hit1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && dst_addr != '0) begin
      r_regs[dst_addr] <= dst;
    end
  end

  // set after clear: a younger load to the same register wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (we) r_busy[dst_addr] <= 1'b0;
      if (ld_issue && ld_dst_addr != '0) begin
        r_busy[ld_dst_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
    end else if (!w_stall) begin
      if (re0) r_p0 <= w_val0;
      if (re1) r_p1 <= w_val1;
    end
  end

  assign p0    = r_p0;
  assign p1    = r_p1;
  assign stall = w_stall;

endmodule

// File: tb/tb_rf_wb_sink.sv
// Bench for rf_wb_sink: directed scenarios plus random traffic
// checked against a register/pending-load reference model.
module tb_rf_wb_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  p0_addr, p1_addr, dst_addr, ld_dst_addr;
  logic        re0, re1, we, ld_issue;
  logic [15:0] dst;
  logic [15:0] p0, p1;
  logic        stall;

  rf_wb_sink #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_addr     (p0_addr),
    .p1_addr     (p1_addr),
    .re0         (re0),
    .re1         (re1),
    .we          (we),
    .dst_addr    (dst_addr),
    .dst         (dst),
    .ld_issue    (ld_issue),
    .ld_dst_addr (ld_dst_addr),
    .p0          (p0),
    .p1          (p1),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_reg [16];
  bit          m_pend [16];
  logic [15:0] e_p0, e_p1;
  logic        got_stall;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_val(input logic [3:0] a);
    if (a == 0) return 16'h0;
    if (we && dst_addr == a) return dst;
    return m_reg[a];
  endfunction

  function automatic bit m_wait(input bit r, input logic [3:0] a);
    return r && m_pend[a] && !(we && dst_addr == a);
  endfunction

  function automatic bit m_stall();
    return m_wait(re0, p0_addr) || m_wait(re1, p1_addr);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = 16'h0;
      m_pend[i] = 1'b0;
    end
    e_p0 = 16'h0;
    e_p1 = 16'h0;
  endtask

  task automatic step(input bit r0, input logic [3:0] a0,
                      input bit r1, input logic [3:0] a1,
                      input bit w, input logic [3:0] da,
                      input logic [15:0] d,
                      input bit li, input logic [3:0] la);
    bit s;
    logic [15:0] v0, v1;
    re0 = r0; p0_addr = a0; re1 = r1; p1_addr = a1;
    we = w; dst_addr = da; dst = d;
    ld_issue = li; ld_dst_addr = la;
    #1;
    got_stall = stall;
    chk("stall", {31'h0, stall}, {31'h0, m_stall()});
    @(posedge clk);
    s  = m_stall();
    v0 = m_val(a0);
    v1 = m_val(a1);
    if (r0 && !s) e_p0 = v0;
    if (r1 && !s) e_p1 = v1;
    if (w && da != 0) m_reg[da] = d;
    if (w) m_pend[da] = 1'b0;
    if (li && la != 0) m_pend[la] = 1'b1;
    @(negedge clk);
    chk("p0", {16'h0, p0}, {16'h0, e_p0});
    chk("p1", {16'h0, p1}, {16'h0, e_p1});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    re0 = 0; re1 = 0; we = 0; ld_issue = 0;
    p0_addr = 0; p1_addr = 0; dst_addr = 0; ld_dst_addr = 0; dst = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_p0", {16'h0, p0}, 32'h0);
    chk("rst_p1", {16'h0, p1}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    rst_n = 1'b1;

    // write then read next cycle
    step(0, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0);
    step(1, 3, 0, 0, 0, 0, 16'h0, 0, 0);
    chk("r3_read", {16'h0, p0}, 32'hBEEF);

    // same-cycle bypass
    step(1, 5, 0, 0, 1, 5, 16'h1234, 0, 0);
    chk("bypass", {16'h0, p0}, 32'h1234);

    // R0 is hardwired zero
    step(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
    step(1, 0, 1, 0, 0, 0, 16'h0, 0, 0);
    chk("r0_p0", {16'h0, p0}, 32'h0);
    chk("r0_p1", {16'h0, p1}, 32'h0);

    // load-use stall and writeback release
    step(0, 0, 0, 0, 0, 0, 16'h0, 1, 7);
    step(0, 0, 1, 7, 0, 0, 16'h0, 0, 0);
    chk("lu_stall", {31'h0, got_stall}, 32'h1);
    chk("lu_hold", {16'h0, p1}, 32'h0);
    step(0, 0, 1, 7, 1, 7, 16'h00AA, 0, 0);
    chk("lu_release", {31'h0, got_stall}, 32'h0);
    chk("lu_data", {16'h0, p1}, 32'h00AA);

    // set/clear race on R4: set wins
    step(0, 0, 0, 0, 0, 0, 16'h0, 1, 4);
    step(0, 0, 0, 0, 1, 4, 16'h5555, 1, 4);
    step(1, 4, 0, 0, 0, 0, 16'h0, 0, 0);
    chk("race_stall", {31'h0, got_stall}, 32'h1);
    step(1, 4, 1, 4, 1, 4, 16'h6666, 0, 0);
    chk("race_p0", {16'h0, p0}, 32'h6666);
    chk("race_p1", {16'h0, p1}, 32'h6666);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit r0, r1, w, li;
      logic [3:0] a0, a1, da, la;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 2) != 0);
      li = ($urandom_range(0, 3) == 0);
      a0 = 4'($urandom);
      a1 = ($urandom_range(0, 4) == 0) ? a0 : 4'($urandom);
      da = 4'($urandom);
      la = 4'($urandom);
      re0 = r0; p0_addr = a0; re1 = r1; p1_addr = a1;
      we = w; dst_addr = da;
      if (m_stall()) li = 1'b0;
      step(r0, a0, r1, a1, w, da, 16'($urandom), li, la);
      if (n == 300) begin
        // asynchronous reset in the middle of traffic
        step(0, 0, 0, 0, 0, 0, 16'h0, 1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p0", {16'h0, p0}, 32'h0);
        chk("mid_rst_p1", {16'h0, p1}, 32'h0);
        chk("mid_rst_stall", {31'h0, stall}, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
          step(1, 4'(i), 1, 4'(15 - i), 0, 0, 16'h0, 0, 0);
          chk("post_rst_p0", {16'h0, p0}, 32'h0);
          chk("post_rst_st", {31'h0, got_stall}, 32'h0);
        end
      end
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
